// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge filter.
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default frame geometry (pixels / rows)
//   MAG_SAT                        : ceiling applied to the gradient magnitude
//   sobel_state_e                  : sequencing FSM state encoding
package sobel_pkg;

  localparam int DEF_IMG_WIDTH  = 720;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int MAG_SAT        = 255;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sobel_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// History shift register for the 3x3 Sobel window.
// Holds the last 2*IMG_WIDTH+2 popped pixels; hist[0] is the most recent one.
// Together with the pixel currently at the FIFO head (din) this covers a full
// 3x3 neighbourhood whose centre is hist[IMG_WIDTH].
//   clock, reset : rising-edge clock, async active-high reset (clears history)
//   shift_en     : shift din into the history this cycle
//   din          : incoming pixel (bottom-right of the window)
//   tap_*        : the eight neighbours of the window centre
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int FIFO_DWIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [FIFO_DWIDTH-1:0] din,
  output logic [FIFO_DWIDTH-1:0] tap_tl,
  output logic [FIFO_DWIDTH-1:0] tap_t,
  output logic [FIFO_DWIDTH-1:0] tap_tr,
  output logic [FIFO_DWIDTH-1:0] tap_l,
  output logic [FIFO_DWIDTH-1:0] tap_r,
  output logic [FIFO_DWIDTH-1:0] tap_bl,
  output logic [FIFO_DWIDTH-1:0] tap_b,
  output logic [FIFO_DWIDTH-1:0] tap_br
);

  localparam int DEPTH = 2 * IMG_WIDTH + 2;

  logic [FIFO_DWIDTH-1:0] hist_q [DEPTH];
  logic [FIFO_DWIDTH-1:0] hist_d [DEPTH];

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  // hist[j] holds the pixel popped j+1 pops ago, so one row back is an
  // offset of IMG_WIDTH and two rows back an offset of 2*IMG_WIDTH.
  assign tap_br = din;
  assign tap_b  = hist_q[0];
  assign tap_bl = hist_q[1];
  assign tap_r  = hist_q[IMG_WIDTH-1];
  assign tap_l  = hist_q[IMG_WIDTH+1];
  assign tap_tr = hist_q[2*IMG_WIDTH-1];
  assign tap_t  = hist_q[2*IMG_WIDTH];
  assign tap_tl = hist_q[2*IMG_WIDTH+1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient-magnitude filter between two FWFT FIFOs.
// Consumes a raster-order grayscale frame and produces exactly one result
// per input pixel in the same raster order; border pixels produce 0.
//   clock, reset   : rising-edge clock, async active-high reset
//   fifo_in_rd_en  : pop the upstream head pixel this cycle
//   fifo_in_dout   : upstream head pixel (valid while !fifo_in_empty)
//   fifo_in_empty  : upstream FIFO empty
//   fifo_out_wr_en : push fifo_out_din downstream this cycle
//   fifo_out_din   : result pixel (0 whenever not writing)
//   fifo_out_full  : downstream FIFO full
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int FIFO_DWIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   fifo_in_rd_en,
  input  logic [FIFO_DWIDTH-1:0] fifo_in_dout,
  input  logic                   fifo_in_empty,
  output logic                   fifo_out_wr_en,
  output logic [FIFO_DWIDTH-1:0] fifo_out_din,
  input  logic                   fifo_out_full
);

  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int PH_W   = $clog2(IMG_WIDTH + 1);
  localparam int GRAD_W = FIFO_DWIDTH + 3;
  localparam int MAG_W  = GRAD_W + 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(IMG_WIDTH);

  sobel_state_e     state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;      // index of the next pixel to pop
  logic [PH_W-1:0]  phase_q, phase_d;  // pops in FILL / writes in FLUSH
  logic [ROW_W-1:0] row_q, row_d;      // window centre position
  logic [COL_W-1:0] col_q, col_d;

  logic pop;
  logic push;

  logic [FIFO_DWIDTH-1:0] tap_tl, tap_t, tap_tr, tap_l, tap_r, tap_bl, tap_b, tap_br;

  function automatic logic signed [GRAD_W-1:0] widen(input logic [FIFO_DWIDTH-1:0] p);
    return $signed({{(GRAD_W - FIFO_DWIDTH){1'b0}}, p});
  endfunction

  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

  function automatic logic [FIFO_DWIDTH-1:0] sat_mag(input logic [MAG_W-1:0] m);
    if (m > MAG_W'(MAG_SAT)) begin
      return FIFO_DWIDTH'(MAG_SAT);
    end
    return m[FIFO_DWIDTH-1:0];
  endfunction

  sobel_line_buffer #(
    .IMG_WIDTH   (IMG_WIDTH),
    .FIFO_DWIDTH (FIFO_DWIDTH)
  ) u_line_buffer (
    .clock    (clock),
    .reset    (reset),
    .shift_en (pop),
    .din      (fifo_in_dout),
    .tap_tl   (tap_tl),
    .tap_t    (tap_t),
    .tap_tr   (tap_tr),
    .tap_l    (tap_l),
    .tap_r    (tap_r),
    .tap_bl   (tap_bl),
    .tap_b    (tap_b),
    .tap_br   (tap_br)
  );

  // Handshakes are combinational so RUN moves one pixel per cycle with no
  // latency; reset gates them so nothing moves while it is asserted.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    case (state_q)
      ST_FILL:  pop  = !fifo_in_empty;
      ST_RUN: begin
        pop  = !fifo_in_empty && !fifo_out_full;
        push = !fifo_in_empty && !fifo_out_full;
      end
      ST_FLUSH: push = !fifo_out_full;
      default: ;
    endcase
    if (reset) begin
      pop  = 1'b0;
      push = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    phase_d = phase_q;
    row_d   = row_q;
    col_d   = col_q;

    if (pop) begin
      pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
    end

    // Every write corresponds to exactly one window centre.
    if (push) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      ST_FILL: begin
        if (pop) begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            state_d = ST_RUN;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (pop && (pix_q == PIX_LAST)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (push) begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            state_d = ST_FILL;
            row_d   = '0;
            col_d   = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      pix_q   <= '0;
      phase_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  logic signed [GRAD_W-1:0] gx, gy;
  logic [MAG_W-1:0]         mag_sum, mag;
  logic                     border;

  assign gx = (widen(tap_tr) + (widen(tap_r) <<< 1) + widen(tap_br))
            - (widen(tap_tl) + (widen(tap_l) <<< 1) + widen(tap_bl));
  assign gy = (widen(tap_bl) + (widen(tap_b) <<< 1) + widen(tap_br))
            - (widen(tap_tl) + (widen(tap_t) <<< 1) + widen(tap_tr));

  assign mag_sum = {1'b0, abs_grad(gx)} + {1'b0, abs_grad(gy)};
  assign mag     = mag_sum >> 1;

  // At the frame edge the window straddles rows/columns, so force 0 there.
  assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                  (col_q == '0) || (col_q == COL_LAST);

  assign fifo_in_rd_en  = pop;
  assign fifo_out_wr_en = push;
  assign fifo_out_din   = (push && (state_q == ST_RUN) && !border) ? sat_mag(mag) : '0;

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter on a 4x4 frame geometry.
module tb_sobel_filter;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clock;
  logic       reset;
  logic       fifo_in_rd_en;
  logic [7:0] fifo_in_dout;
  logic       fifo_in_empty;
  logic       fifo_out_wr_en;
  logic [7:0] fifo_out_din;
  logic       fifo_out_full;

  int n_vec = 0;
  int n_err = 0;
  int pops = 0;
  int writes = 0;

  logic [7:0] in_q [$];
  logic [7:0] out_q [$];
  int         exp_q [$];
  int         frm [H][W];

  sobel_filter #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .FIFO_DWIDTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO handshake rules, sampled mid-cycle.
  always @(negedge clock) begin
    n_vec++;
    if (fifo_in_rd_en === 1'b1 && fifo_in_empty === 1'b1) begin
      n_err++;
      $display("FAIL pop_while_empty: rd_en=%b empty=%b", fifo_in_rd_en, fifo_in_empty);
    end
    n_vec++;
    if (fifo_out_wr_en === 1'b1 && fifo_out_full === 1'b1) begin
      n_err++;
      $display("FAIL write_while_full: wr_en=%b full=%b", fifo_out_wr_en, fifo_out_full);
    end
    n_vec++;
    if (fifo_out_wr_en !== 1'b1 && fifo_out_din !== 8'd0) begin
      n_err++;
      $display("FAIL din_idle_zero: din=%0d required 0 (wr_en=%b)", fifo_out_din, fifo_out_wr_en);
    end
  end

  // Behavioural reference: Sobel magnitude straight from the 2-D frame.
  function automatic int ref_pixel(int r, int c);
    int gx, gy, m;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = (frm[r-1][c+1] + 2*frm[r][c+1] + frm[r+1][c+1])
       - (frm[r-1][c-1] + 2*frm[r][c-1] + frm[r+1][c-1]);
    gy = (frm[r+1][c-1] + 2*frm[r+1][c] + frm[r+1][c+1])
       - (frm[r-1][c-1] + 2*frm[r-1][c] + frm[r-1][c+1]);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic load_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        in_q.push_back(8'(frm[r][c]));
        exp_q.push_back(ref_pixel(r, c));
      end
  endtask

  task automatic random_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frm[r][c] = $urandom_range(255);
  endtask

  // One clock: present FIFO state, observe the handshakes, update the FIFOs.
  task automatic step(input bit gap_in, input bit hold_out, output bit popped, output bit pushed);
    fifo_in_empty = gap_in || (in_q.size() == 0);
    fifo_in_dout  = fifo_in_empty ? 8'($urandom) : in_q[0];
    fifo_out_full = hold_out;
    @(negedge clock);
    popped = (fifo_in_rd_en === 1'b1) && !fifo_in_empty;
    pushed = (fifo_out_wr_en === 1'b1) && !fifo_out_full;
    if (popped) begin
      void'(in_q.pop_front());
      pops++;
    end
    if (pushed) begin
      out_q.push_back(fifo_out_din);
      writes++;
    end
    @(posedge clock);
    #1;
  endtask

  // Run until every expected output has arrived (bounded), with optional
  // 1-5 cycle input gaps, random single-cycle output stalls, and one
  // 10-cycle output stall starting when the pop count hits full_at_pop.
  task automatic drain(input int gap_pct, input int full_pct, input int full_at_pop,
                       output bit timed_out, output int stall_pops, output int stall_writes);
    int  budget, gap_left, full_left;
    bit  full_done, g, f, p, w;
    budget = 3000; gap_left = 0; full_left = 0; full_done = 0;
    stall_pops = 0; stall_writes = 0; timed_out = 0;
    while (out_q.size() < exp_q.size()) begin
      if (budget == 0) begin
        timed_out = 1;
        break;
      end
      budget--;
      if (!full_done && full_at_pop >= 0 && pops == full_at_pop) begin
        full_left = 10;
        full_done = 1;
      end
      g = 0;
      if (full_left == 0) begin
        if (gap_left > 0) begin
          g = 1;
          gap_left--;
        end else if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          g = 1;
          gap_left = $urandom_range(4);
        end
      end
      f = (full_left > 0) || (full_pct > 0 && $urandom_range(99) < full_pct);
      step(g, f, p, w);
      if (full_left > 0) begin
        if (p) stall_pops++;
        if (w) stall_writes++;
        full_left--;
      end
    end
    for (int i = 0; i < 6; i++) step(0, 0, p, w);
  endtask

  task automatic test_reset();
    bit p, w;
    reset = 1'b1;
    in_q.push_back(8'd55);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, p, w);
      n_vec++;
      if (p || w) begin
        n_err++;
        $display("FAIL reset_idle: pop=%b write=%b required 0 0", p, w);
      end
    end
    n_vec++;
    if (fifo_in_rd_en !== 1'b0 || fifo_out_wr_en !== 1'b0 || fifo_out_din !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b din=%0d required 0 0 0",
               fifo_in_rd_en, fifo_out_wr_en, fifo_out_din);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (fifo_in_rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL fill_rd_en: rd_en=%b required 1", fifo_in_rd_en);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (fifo_in_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_rd_en: rd_en=%b required 0", fifo_in_rd_en);
    end
    step(0, 0, p, w);
    in_q.delete();
    step(0, 0, p, w);
    reset = 1'b0;
    n_vec++;
    if (pops !== 0) begin
      n_err++;
      $display("FAIL pops_during_reset: pops=%0d required 0", pops);
    end
  endtask

  task automatic test_flat();
    bit to; int sp, sw;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frm[r][c] = 100;
    load_frame();
    drain(0, 0, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != N) begin
      n_err++;
      $display("FAIL flat_count: outputs=%0d required %0d (timeout=%b)", out_q.size(), N, to);
    end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      n_vec++;
      if (out_q[i] !== 8'd0) begin
        n_err++;
        $display("FAIL flat_px%0d: got %0d required 0", i, out_q[i]);
      end
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_columns(input int val);
    bit to; int sp, sw, req, r, c;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++) frm[rr][cc] = (cc < 2) ? 0 : val;
    load_frame();
    drain(0, 0, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != N) begin
      n_err++;
      $display("FAIL col%0d_count: outputs=%0d required %0d (timeout=%b)", val, out_q.size(), N, to);
    end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      r = i / W;
      c = i % W;
      req = (r >= 1 && r <= 2 && c >= 1 && c <= 2) ? ((2*val > 255) ? 255 : 2*val) : 0;
      n_vec++;
      if (out_q[i] !== 8'(req)) begin
        n_err++;
        $display("FAIL col%0d_px%0d: got %0d required %0d", val, i, out_q[i], req);
      end
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_stalls();
    bit to; int sp, sw;
    random_frame();
    load_frame();
    drain(30, 0, pops + 8, to, sp, sw);
    n_vec++;
    if (sp != 0 || sw != 0) begin
      n_err++;
      $display("FAIL full_stall_activity: pops=%0d writes=%0d required 0 0", sp, sw);
    end
    for (int f = 0; f < 3; f++) begin
      random_frame();
      load_frame();
    end
    drain(25, 25, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stall_count: outputs=%0d required %0d (timeout=%b)", out_q.size(), exp_q.size(), to);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (out_q[i] !== 8'(exp_q[i])) begin
        n_err++;
        $display("FAIL stall_px%0d: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit to; int sp, sw;
    for (int f = 0; f < 5; f++) begin
      random_frame();
      load_frame();
    end
    drain(0, 0, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != 5*N) begin
      n_err++;
      $display("FAIL b2b_count: outputs=%0d required %0d (timeout=%b)", out_q.size(), 5*N, to);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (out_q[i] !== 8'(exp_q[i])) begin
        n_err++;
        $display("FAIL b2b_px%0d: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    bit to, p, w; int sp, sw, target, budget;
    random_frame();
    load_frame();
    target = pops + 7;
    budget = 100;
    while (pops < target && budget > 0) begin
      step(0, 0, p, w);
      budget--;
    end
    n_vec++;
    if (pops != target) begin
      n_err++;
      $display("FAIL abort_pops: pops=%0d required %0d", pops, target);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (fifo_in_rd_en !== 1'b0 || fifo_out_wr_en !== 1'b0 || fifo_out_din !== 8'd0) begin
      n_err++;
      $display("FAIL midframe_reset_outputs: rd=%b wr=%b din=%0d required 0 0 0",
               fifo_in_rd_en, fifo_out_wr_en, fifo_out_din);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, p, w);
      n_vec++;
      if (p || w) begin
        n_err++;
        $display("FAIL midframe_reset_idle: pop=%b write=%b required 0 0", p, w);
      end
    end
    in_q.delete(); out_q.delete(); exp_q.delete();
    reset = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frm[r][c] = 100;
    load_frame();
    drain(0, 0, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != N) begin
      n_err++;
      $display("FAIL post_reset_count: outputs=%0d required %0d (timeout=%b)", out_q.size(), N, to);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      n_vec++;
      if (out_q[i] !== 8'd0) begin
        n_err++;
        $display("FAIL post_reset_px%0d: got %0d required 0", i, out_q[i]);
      end
    end
    out_q.delete(); exp_q.delete();
    random_frame();
    load_frame();
    drain(10, 10, -1, to, sp, sw);
    n_vec++;
    if (to || out_q.size() != N) begin
      n_err++;
      $display("FAIL realign_count: outputs=%0d required %0d (timeout=%b)", out_q.size(), N, to);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (out_q[i] !== 8'(exp_q[i])) begin
        n_err++;
        $display("FAIL realign_px%0d: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
    out_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset         = 1'b1;
    fifo_in_empty = 1'b1;
    fifo_in_dout  = 8'd0;
    fifo_out_full = 1'b0;
    test_reset();
    test_flat();
    test_columns(40);
    test_columns(255);
    test_stalls();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
